approx_adder_err_meter: RTL
===========================

# approx_adder_err_meter

Self-contained sequential error characteriser for the approximate ripple-carry adders in the power/MSE adder family. After `start`, it sweeps every operand pair (a, b) of a WIDTH-bit approximate adder and computes two sums for each pair:
- the approximate sum: the low APPROX_BITS positions use the approximate cell, the upper positions use exact full adders;
- the exact sum.

It accumulates error count, maximum absolute error, sum of absolute errors, sum of squared errors, and the first worst-case operand pair. The block sits beside the adder library as its measurement end: the adder produces sums, this block consumes and grades them.

## Interface
Parameters:
- WIDTH, 8, operand width; sweep length N = 2^(2·WIDTH)
- APPROX_BITS, 7, number of low bit positions using the approximate cell (0..WIDTH-1); 0 gives an exact adder

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset: one clock, synchronous, active-high; overrides every other input
- start  in  1  begin a sweep; sampled only in IDLE
- hold  in  1  freezes the whole datapath (counter, pipeline, accumulators) while high in RUN/DRAIN
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when results are final
- err_count  out  2·WIDTH+1  pairs with approx ≠ exact
- max_abs_err  out  WIDTH+1  largest |approx − exact|
- sum_abs_err  out  3·WIDTH+1  Σ|e|
- sum_sq_err  out  4·WIDTH+2  Σe²
- worst_a, worst_b  out  WIDTH each  first pair (sweep order) reaching max_abs_err

## Operation
Approximate cell (bit i < APPROX_BITS):
- S = X | Y | Z
- Cout = X & Y

Exact cell (i ≥ APPROX_BITS):
- S = X ^ Y ^ Z
- Cout = majority(X, Y, Z)

Chain rules:
- Carry-in of bit 0 is 0.
- Result is WIDTH+1 bits; the MSB is the final carry.
- Exact reference = a + b, WIDTH+1 bits.
- e = approx − exact, signed; |e| < 2^(WIDTH+1).

Sweep order: a 2·WIDTH-bit counter {a, b}, with b in the low half, runs 0 .. N−1 with no wrap.

FSM:
- IDLE: `start` → RUN. On that transition, clear the counter and all result outputs to 0.
- RUN: issue one pair per non-held cycle. After issuing pair N−1 → DRAIN.
- DRAIN: 2 non-held cycles. Leaving DRAIN → IDLE with `done` = 1 for exactly that cycle.

Pipeline, 3 stages, all frozen by `hold`:
- S0: operand register.
- S1: approx and exact sums.
- S2: |e| and e².
- Accumulate: results updated from S2.
- Valid bits track bubbles, so no pair is double-counted or dropped.

Max/worst tracking:
- Update `max_abs_err`, `worst_a`, `worst_b` only when |e| > current max (strict).
- Ties therefore keep the earliest pair.

Results hold after `done` until the next accepted `start` or `rst`.

## Timing
- Reset values: busy=0, done=0, and every result output = 0. FSM goes to IDLE.
- Let start be sampled at edge T:
  - busy=1 from cycle T+1.
  - Pair k is included in the results after edge T+3+k, plus held cycles.
  - done=1 in the cycle after edge T+N+2+H, where H = number of held cycles; busy=0 in the same cycle.
  - For WIDTH=8 with no hold, done follows the 65538th edge after T.
- `start` while busy, or in the done cycle, is ignored; it is accepted from the following IDLE cycle.
- `hold` in IDLE has no effect.
- `hold` and `rst` together: `rst` wins.
- `rst` mid-sweep: the next cycle is IDLE with all outputs 0. No done pulse and no partial results.
- Accumulator widths are sized so no overflow is possible at maximum N and |e|. No saturation logic.

## Test plan
- WIDTH=2, APPROX_BITS=0, start, no hold → done 18 cycles after start edge; all metrics 0; worst_a = worst_b = 0.
- WIDTH=2, APPROX_BITS=1 → err_count=4, max_abs_err=1, sum_abs_err=4, sum_sq_err=4, worst_a=1, worst_b=1 (first pair with a0 = b0 = 1).
- WIDTH=8, APPROX_BITS=7, single-pair spot checks against the S1 probe:
  - (1,1) → approx 3, exact 2.
  - (255,255) → 511 vs 510.
  - (0,0) → 0.
  Full-sweep metrics must equal the bit-accurate golden model.
- WIDTH=2, APPROX_BITS=1, hold high for 5 random cycles during RUN and 2 during DRAIN → identical metrics to the no-hold run; done 7 cycles later (25 after start).
- `rst` asserted mid-RUN → next cycle busy=0, all outputs 0, no done. A fresh start then reproduces the clean-run results.
- `start` held high continuously → sweeps run back-to-back. Each restart is accepted 1 cycle after the done pulse, and results clear to 0 on acceptance.

Source files
------------

// File: rtl/approx_adder_err_meter.sv
// Exhaustive error characteriser for an approximate ripple-carry adder.
// Sweeps every {a,b} pair and grades the approximate sum against a + b.
module approx_adder_err_meter #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH:0]       max_abs_err,
  output logic [3*WIDTH:0]     sum_abs_err,
  output logic [4*WIDTH+1:0]   sum_sq_err,
  output logic [WIDTH-1:0]     worst_a,
  output logic [WIDTH-1:0]     worst_b
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     pair_cnt;
  logic              drain_cnt;
  logic              accept;
  logic              finish;

  logic              v1;
  logic [WIDTH-1:0]  s1_a, s1_b;
  logic [WIDTH:0]    s1_apx, s1_ext;

  logic              v2;
  logic [WIDTH-1:0]  s2_a, s2_b;
  logic [WIDTH:0]    s2_abs;
  logic [2*WIDTH+1:0] s2_sq;

  logic [WIDTH+1:0]  diff;
  logic [WIDTH+1:0]  diff_mag;
  logic [WIDTH:0]    e_abs;
  logic [2*WIDTH+1:0] e_sq;

  function automatic logic [WIDTH:0] approx_sum(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic           c;
    logic [WIDTH:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < APPROX_BITS) begin
        s[i] = x[i] | y[i] | c;
        c    = x[i] & y[i];
      end else begin
        s[i] = x[i] ^ y[i] ^ c;
        c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      end
    end
    s[WIDTH] = c;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A start arriving while the done pulse is up is ignored, so back-to-back
  // sweeps restart one cycle after done.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (!hold && (pair_cnt == '1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!hold && drain_cnt) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt  <= '0;
      drain_cnt <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        pair_cnt  <= '0;
        drain_cnt <= 1'b0;
      end else if (!hold) begin
        if (state == RUN && pair_cnt != '1)
          pair_cnt <= pair_cnt + {{(CW-1){1'b0}}, 1'b1};
        if (state == DRAIN)
          drain_cnt <= ~drain_cnt;
      end
    end
  end

  // The pair counter doubles as the operand stage; S1 latches both sums.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      v1     <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_apx <= '0;
      s1_ext <= '0;
    end else if (!hold) begin
      v1     <= (state == RUN);
      s1_a   <= pair_cnt[CW-1:WIDTH];
      s1_b   <= pair_cnt[WIDTH-1:0];
      s1_apx <= approx_sum(pair_cnt[CW-1:WIDTH], pair_cnt[WIDTH-1:0]);
      s1_ext <= {1'b0, pair_cnt[CW-1:WIDTH]} + {1'b0, pair_cnt[WIDTH-1:0]};
    end
  end

  always_comb begin
    diff     = {1'b0, s1_apx} - {1'b0, s1_ext};
    diff_mag = diff[WIDTH+1] ? (~diff + {{(WIDTH+1){1'b0}}, 1'b1}) : diff;
    e_abs    = diff_mag[WIDTH:0];
    e_sq     = {{(WIDTH+1){1'b0}}, e_abs} * {{(WIDTH+1){1'b0}}, e_abs};
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      v2     <= 1'b0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_abs <= '0;
      s2_sq  <= '0;
    end else if (!hold) begin
      v2     <= v1;
      s2_a   <= s1_a;
      s2_b   <= s1_b;
      s2_abs <= e_abs;
      s2_sq  <= e_sq;
    end
  end

  // Strict greater-than keeps the earliest pair on ties.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_count   <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
    end else if (v2 && !hold) begin
      err_count   <= err_count + {{CW{1'b0}}, (s2_abs != '0)};
      sum_abs_err <= sum_abs_err + {{(2*WIDTH){1'b0}}, s2_abs};
      sum_sq_err  <= sum_sq_err + {{(2*WIDTH){1'b0}}, s2_sq};
      if (s2_abs > max_abs_err) begin
        max_abs_err <= s2_abs;
        worst_a     <= s2_a;
        worst_b     <= s2_b;
      end
    end
  end

endmodule
